quad_decoder: RTL and testbench

//  Quadrature (A/B) encoder decoder. Turns two raw, asynchronous phase inputs into step/dir

---
 rtl/quad_decoder.sv | 144 ++++++++++++++
 tb/tb_quad_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature (A/B) encoder decoder producing step/dir pulses and a
//   wrapping position count from two raw asynchronous phase inputs.
// Latency: AB level stable from sampling edge k -> outputs update on edge
//   k + SYNC_STAGES + FILTER_LEN + 1 (6 with defaults). No backpressure; outputs are pulses.
// Ports: clk (rising edge), reset (async, active-low), a_in/b_in (async phases),
//   clr (sync count clear), step/err (1-cycle pulses), dir (last direction), count (position).
module quad_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             err
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] a_sync_q, a_sync_d;
  logic [SYNC_STAGES-1:0] b_sync_q, b_sync_d;
  logic [1:0]             s;

  logic [1:0]       filt_q, filt_d;
  logic [1:0]       cand_q, cand_d;
  logic [CNT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             init_q, init_d;

  // Accepted transition waiting to be decoded on the following edge.
  logic             pend_q, pend_d;
  logic [1:0]       pend_old_q, pend_old_d;
  logic [1:0]       pend_new_q, pend_new_d;

  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] count_q, count_d;

  // Map Gray-coded AB onto a position 0..3 along the forward cycle
  // 00->01->11->10, so a transition is simply the modulo-4 position delta.
  logic [1:0] pos_old, pos_new, pos_diff;

  assign s        = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
  assign pos_old  = {pend_old_q[1], pend_old_q[1] ^ pend_old_q[0]};
  assign pos_new  = {pend_new_q[1], pend_new_q[1] ^ pend_new_q[0]};
  assign pos_diff = pos_new - pos_old;

  always_comb begin
    a_sync_d   = {a_sync_q[SYNC_STAGES-2:0], a_in};
    b_sync_d   = {b_sync_q[SYNC_STAGES-2:0], b_in};
    filt_d     = filt_q;
    cand_d     = cand_q;
    flt_cnt_d  = flt_cnt_q;
    init_d     = init_q;
    pend_d     = 1'b0;
    pend_old_d = pend_old_q;
    pend_new_d = pend_new_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    dir_d      = dir_q;
    count_d    = count_q;

    // Glitch filter. Before the first acceptance every sample counts as
    // "different", so a steady 00 after reset still gets accepted once.
    if (flt_cnt_q == CNT_W'(FILTER_LEN)) begin
      flt_cnt_d  = '0;
      filt_d     = cand_q;
      init_d     = 1'b1;
      pend_d     = init_q;   // first acceptance only seeds the state
      pend_old_d = filt_q;
      pend_new_d = cand_q;
    end else if (init_q && (s == filt_q)) begin
      flt_cnt_d = '0;
    end else if ((flt_cnt_q != '0) && (s == cand_q)) begin
      flt_cnt_d = flt_cnt_q + CNT_W'(1);
    end else begin
      flt_cnt_d = CNT_W'(1);
      cand_d    = s;
    end

    if (pend_q) begin
      case (pos_diff)
        2'd1: begin
          step_d  = 1'b1;
          dir_d   = 1'b1;
          count_d = count_q + WIDTH'(1);
        end
        2'd3: begin
          step_d  = 1'b1;
          dir_d   = 1'b0;
          count_d = count_q - WIDTH'(1);
        end
        2'd2:    err_d = 1'b1;   // both phases moved: state resyncs, count untouched
        default: ;
      endcase
    end

    // Clear wins over a simultaneous step; step/dir are still reported.
    if (clr) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sync_q   <= '0;
      b_sync_q   <= '0;
      filt_q     <= 2'b00;
      cand_q     <= 2'b00;
      flt_cnt_q  <= '0;
      init_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_old_q <= 2'b00;
      pend_new_q <= 2'b00;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      a_sync_q   <= a_sync_d;
      b_sync_q   <= b_sync_d;
      filt_q     <= filt_d;
      cand_q     <= cand_d;
      flt_cnt_q  <= flt_cnt_d;
      init_q     <= init_d;
      pend_q     <= pend_d;
      pend_old_q <= pend_old_d;
      pend_new_q <= pend_new_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  assign step  = step_q;
  assign dir   = dir_q;
  assign err   = err_q;
  assign count = count_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: randomized and directed AB stimulus against a
// window-based reference model; expected step/err events go through a queue.
module tb_quad_decoder;
  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int FL    = 3;
  localparam int MODN  = 1 << WIDTH;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_in = 1'b0;
  logic b_in = 1'b0;
  logic clr = 1'b0;
  logic step, dir, err;
  logic [WIDTH-1:0] count;

  quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .clr(clr),
    .step(step), .dir(dir), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    bit is_err;
    bit dir;
    int cnt;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  // Reference model: a new AB value is accepted at edge E when the FILTER_LEN
  // synchronised samples just before E all equal it, differ from the current
  // filtered state, and all follow the previous acceptance edge.
  logic [1:0] in_hist [0:4095];
  int         m_e, last_acc, m_cnt;
  logic [1:0] m_fstate, m_old, m_new;
  bit         m_init, m_pend, m_dir;
  int         fwd_order [4] = '{0, 1, 3, 2};

  function automatic int seq_idx(input logic [1:0] ab);
    int r = 0;
    for (int i = 0; i < 4; i++) if (fwd_order[i] == int'(ab)) r = i;
    return r;
  endfunction

  function automatic logic [1:0] s_at(input int j);
    if (j - SYNC >= 1) return in_hist[j - SYNC];
    return 2'b00;
  endfunction

  task automatic model_edge(input bit r, input bit a, input bit b, input bit c);
    int d;
    bit all_same;
    logic [1:0] v;
    if (!r) begin
      m_e = 0; last_acc = 0; m_cnt = 0; m_dir = 0;
      m_fstate = 2'b00; m_init = 0; m_pend = 0;
      return;
    end
    m_e++;
    in_hist[m_e] = {a, b};
    if (m_pend) begin
      d = (seq_idx(m_new) - seq_idx(m_old) + 4) % 4;
      if (d == 1) begin m_cnt = (m_cnt + 1) % MODN; m_dir = 1; end
      if (d == 3) begin m_cnt = (m_cnt + MODN - 1) % MODN; m_dir = 0; end
      if (c) m_cnt = 0;
      exp_q.push_back('{is_err: (d == 2), dir: m_dir, cnt: m_cnt, cyc: cyc + 1});
      m_pend = 0;
    end else if (c) begin
      m_cnt = 0;
    end
    if (m_e - FL >= last_acc + 1) begin
      v = s_at(m_e - 1);
      all_same = 1;
      for (int j = m_e - FL; j < m_e; j++) if (s_at(j) != v) all_same = 0;
      if (all_same && (!m_init || v != m_fstate)) begin
        if (m_init) begin m_pend = 1; m_old = m_fstate; m_new = v; end
        m_fstate = v;
        m_init = 1;
        last_acc = m_e;
      end
    end
  endtask

  task automatic tick(input bit r, input bit a, input bit b, input bit c);
    @(negedge clk);
    reset = r; a_in = a; b_in = b; clr = c;
    model_edge(r, a, b, c);
  endtask

  task automatic hold(input logic [1:0] ab, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, ab[1], ab[0], 1'b0);
  endtask

  // Monitor: pop an expectation whenever the DUT pulses step or err.
  initial begin
    ev_t ev;
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        check("missed_event_cycle", cyc, ev.cyc);
      end
      if (reset && (step || err)) begin
        check("step_err_exclusive", step & err, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_event", int'(step) + int'(err), 0);
        end else begin
          ev = exp_q.pop_front();
          check("event_is_err", err, ev.is_err);
          check("event_dir", dir, ev.dir);
          check("event_count", count, ev.cnt);
          check("event_cycle", cyc, ev.cyc);
        end
      end
    end
  end

  initial begin
    logic [1:0] cur, nxt;
    int mode, len, k;

    // Reset held with toggling phases: everything stays zero.
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2));
      #6;
      check("reset_outputs", {count, step, err, dir}, 0);
    end

    // Init on 11: no step, no err, count 0.
    hold(2'b11, 12);
    #6;
    check("init_count", count, 0);
    check("init_dir", dir, 0);

    // Mid-run reset, then init on 00 and a forward sweep.
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    #6;
    check("midreset_outputs", {count, step, err, dir}, 0);
    hold(2'b00, 10);
    hold(2'b01, 8);
    hold(2'b11, 8);
    hold(2'b10, 8);
    hold(2'b00, 8);
    #6;
    check("fwd_count", count, 4);
    check("fwd_dir", dir, 1);

    // Reverse with wrap from 0.
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    hold(2'b00, 2);
    #6;
    check("clr_count", count, 0);
    hold(2'b10, 8);
    #6;
    check("rev_wrap_count", count, MODN - 1);
    check("rev_dir", dir, 0);
    hold(2'b11, 8);
    #6;
    check("rev_count2", count, MODN - 2);

    // Short glitch on A ignored; 11->00 raises err and leaves count alone.
    hold(2'b01, 2);
    hold(2'b11, 8);
    #6;
    check("glitch_count", count, MODN - 2);
    hold(2'b00, 10);
    #6;
    check("illegal_count", count, MODN - 2);
    check("illegal_dir", dir, 0);

    // Step to 7, then clear on the same edge as the next forward step.
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8); hold(2'b00, 8);
    hold(2'b01, 8); hold(2'b11, 8); hold(2'b10, 8);
    #6;
    check("pre_clr_count", count, 7);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, m_pend);
    #6;
    check("clr_step_count", count, 0);
    check("clr_step_dir", dir, 1);

    // Randomized walk: neighbours, illegal jumps, short glitches, random clears.
    cur = 2'b00;
    for (int seg = 0; seg < 150; seg++) begin
      mode = $urandom % 8;
      k = seq_idx(cur);
      if (mode < 3)      nxt = 2'(fwd_order[(k + 1) % 4]);
      else if (mode < 6) nxt = 2'(fwd_order[(k + 3) % 4]);
      else if (mode == 6) nxt = 2'(fwd_order[(k + 2) % 4]);
      else               nxt = cur;
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++)
        tick(1'b1, nxt[1], nxt[0], ($urandom % 32) == 0);
      cur = nxt;
    end
    hold(cur, 10);
    #6;
    check("final_count", count, m_cnt);
    check("pending_events", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
